// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer,
// a bubble-zeroed control field, synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               load_main_in, load_main_skid, load_skid;
  logic               accept, pop;
  logic [DATA_W-1:0]  main_data_q, skid_data_q;
  logic [CTRL_W-1:0]  main_ctrl_q, skid_ctrl_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  // ready_o depends only on the state register, so ready_i never reaches it combinationally
  assign ready_o     = (state_q != FULL);
  assign valid_o     = (state_q != EMPTY);
  assign accept      = valid_i && ready_o;
  assign pop         = valid_o && ready_i;
  assign occ_o       = state_q;
  assign data_o      = main_data_q;
  assign ctrl_o      = valid_o ? main_ctrl_q : '0;
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Payload registers carry no valid bit; occupancy lives entirely in state_q
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_main_in) begin
        main_data_q <= data_i;
        main_ctrl_q <= ctrl_i;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= data_i;
        skid_ctrl_q <= ctrl_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table with hand-derived expectations,
// a FIFO scoreboard checked on every downstream pop, and hand sequences for stall and reset.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CTRL_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .ctrl_o(ctrl_o),
    .data_o(data_o), .occ_o(occ_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [7:0] c;
    logic       r;
    logic       f;
    logic       ev;
    logic [1:0] eo;
    logic       er;
    logic [7:0] ed;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  ent_t        sb[$];
  int unsigned stall_exp;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic vec_t mk(logic v, logic [7:0] d, logic [7:0] c, logic r, logic f,
                              logic ev, logic [1:0] eo, logic er, logic [7:0] ed);
    vec_t t;
    t = '{v: v, d: d, c: c, r: r, f: f, ev: ev, eo: eo, er: er, ed: ed};
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, score pops/accepts against the model, check #1 after posedge
  task automatic step(input vec_t t);
    ent_t e;
    logic m_valid, m_ready;
    @(negedge clk_i);
    valid_i = t.v;
    data_i  = {56'd0, t.d};
    ctrl_i  = t.c;
    ready_i = t.r;
    flush_i = t.f;
    m_valid = (sb.size() != 0);
    m_ready = (sb.size() < 2);
    check("ready_pre", 64'(ready_o), 64'(m_ready));
    if (m_valid && t.r) begin
      e = sb.pop_front();
      check("sb_data", data_o, e.data);
      check("sb_ctrl", 64'(ctrl_o), 64'(e.ctrl));
    end
    if (m_valid && !t.r && stall_exp < CNT_MAX) stall_exp++;
    if (t.f) sb.delete();
    else if (t.v && m_ready) begin
      e.data = {56'd0, t.d};
      e.ctrl = t.c;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    check("valid_o", 64'(valid_o), 64'(t.ev));
    check("occ_o", 64'(occ_o), 64'(t.eo));
    check("ready_o", 64'(ready_o), 64'(t.er));
    check("data_o", data_o, {56'd0, t.ed});
    check("ctrl_o", 64'(ctrl_o), (sb.size() != 0) ? 64'(sb[0].ctrl) : 64'd0);
    check("stall_cnt", 64'(stall_cnt_o), 64'(stall_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    tbl[0]  = mk(1, 8'h11, 8'hA5, 1, 0,  1, 2'd1, 1, 8'h11);
    tbl[1]  = mk(1, 8'h12, 8'h5A, 1, 0,  1, 2'd1, 1, 8'h12);
    tbl[2]  = mk(1, 8'h13, 8'h3C, 1, 0,  1, 2'd1, 1, 8'h13);
    tbl[3]  = mk(0, 8'h00, 8'h00, 1, 0,  0, 2'd0, 1, 8'h13);
    tbl[4]  = mk(1, 8'h21, 8'h81, 0, 0,  1, 2'd1, 1, 8'h21);
    tbl[5]  = mk(1, 8'h22, 8'h82, 0, 0,  1, 2'd2, 0, 8'h21);
    tbl[6]  = mk(0, 8'h00, 8'h00, 1, 0,  1, 2'd1, 1, 8'h22);
    tbl[7]  = mk(0, 8'h00, 8'h00, 1, 0,  0, 2'd0, 1, 8'h22);
    tbl[8]  = mk(1, 8'h31, 8'h91, 0, 0,  1, 2'd1, 1, 8'h31);
    tbl[9]  = mk(1, 8'h32, 8'h92, 0, 0,  1, 2'd2, 0, 8'h31);
    tbl[10] = mk(1, 8'h3F, 8'h9F, 0, 0,  1, 2'd2, 0, 8'h31);
    tbl[11] = mk(1, 8'h33, 8'h93, 0, 1,  0, 2'd0, 1, 8'h31);
    tbl[12] = mk(0, 8'h00, 8'h00, 1, 0,  0, 2'd0, 1, 8'h31);
    tbl[13] = mk(1, 8'h54, 8'hC4, 1, 0,  1, 2'd1, 1, 8'h54);
    tbl[14] = mk(1, 8'h55, 8'hC5, 1, 0,  1, 2'd1, 1, 8'h55);
    tbl[15] = mk(0, 8'h00, 8'h00, 1, 0,  0, 2'd0, 1, 8'h55);
    tbl[16] = mk(1, 8'h61, 8'hE1, 1, 0,  1, 2'd1, 1, 8'h61);
    tbl[17] = mk(1, 8'h62, 8'hE2, 1, 1,  0, 2'd0, 1, 8'h61);

    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    ctrl_i = '0; data_i = '0;
    stall_exp = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_occ", 64'(occ_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_data", data_o, 64'd0);
    check("rst_ctrl", 64'(ctrl_o), 64'd0);
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 18; i++) step(tbl[i]);
    check("sb_empty_after_table", 64'(sb.size()), 64'd0);

    // Stall saturation: hold one entry with ready_i low for 20 cycles
    step(mk(1, 8'h71, 8'hF1, 0, 0, 1, 2'd1, 1, 8'h71));
    for (int i = 0; i < 20; i++) step(mk(0, 8'h00, 8'h00, 0, 0, 1, 2'd1, 1, 8'h71));
    check("stall_saturated", 64'(stall_cnt_o), 64'(CNT_MAX));
    step(mk(0, 8'h00, 8'h00, 1, 0, 0, 2'd0, 1, 8'h71));
    step(mk(0, 8'h00, 8'h00, 1, 0, 0, 2'd0, 1, 8'h71));
    check("stall_held", 64'(stall_cnt_o), 64'(CNT_MAX));

    // Asynchronous reset between edges while FULL
    step(mk(1, 8'h81, 8'hA1, 0, 0, 1, 2'd1, 1, 8'h81));
    step(mk(1, 8'h82, 8'hA2, 0, 0, 1, 2'd2, 0, 8'h81));
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    valid_i = 1'b1; data_i = 64'h99; ctrl_i = 8'h99; ready_i = 1'b1;
    #1;
    sb.delete();
    stall_exp = 0;
    check("arst_valid", 64'(valid_o), 64'd0);
    check("arst_ctrl", 64'(ctrl_o), 64'd0);
    check("arst_occ", 64'(occ_o), 64'd0);
    check("arst_stall", 64'(stall_cnt_o), 64'd0);
    check("arst_ready", 64'(ready_o), 64'd1);
    check("arst_data", data_o, 64'd0);
    @(posedge clk_i);
    #1;
    check("arst_ignore_in", 64'(occ_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step(mk(1, 8'h44, 8'hB4, 1, 0, 1, 2'd1, 1, 8'h44));
    step(mk(0, 8'h00, 8'h00, 1, 0, 0, 2'd0, 1, 8'h44));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, general-purpose pipeline stage register for the 5-stage CPU.
- Replaces the fixed-width, stall/flush-only stage registers between IF/ID/EX/MEM/WB.
- Valid/ready handshake with a 2-entry skid buffer, so back-pressure does not need a combinational ready path across stages.
- Separate control field, forced to zero on bubbles; synchronous flush; saturating stall counter.

Parameters:
- DATA_W, 64, width of datapath payload (PC, operands, immediates, register addresses).
- CTRL_W, 8, width of control payload (WB/M/EX bits); forced to 0 when output not valid.
- CNT_W, 16, width of stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush: discard all held entries.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept an entry this cycle; registered.
- ctrl_i  in  CTRL_W  upstream control payload.
- data_i  in  DATA_W  upstream data payload.
- valid_o  out  1  downstream entry valid.
- ready_i  in  1  downstream accepts this cycle.
- ctrl_o  out  CTRL_W  control payload; all-zero whenever valid_o=0 (bubble).
- data_o  out  DATA_W  data payload; holds last value when valid_o=0.
- occ_o  out  2  entries held: 0, 1 or 2.
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0; saturating.

Behaviour:
- Reset (rst_i=0, async):
  - main and skid valid cleared; occ_o=0, valid_o=0, ctrl_o=0, data_o=0.
  - ready_o=1, stall_cnt_o=0.
  - Inputs ignored while reset is asserted; applies mid-transfer, all in-flight entries are lost.
- Handshakes:
  - Accept when valid_i && ready_o.
  - Pop when valid_o && ready_i.
  - ready_o = !skid_valid, registered; no combinational path from ready_i to ready_o.
- States, and transitions at each clock edge when flush_i=0:
  - EMPTY (occ 0):
    - accept -> ONE; main<=input.
    - else stay EMPTY.
  - ONE (occ 1):
    - accept & pop -> ONE; main<=input.
    - accept & !pop -> FULL; skid<=input.
    - !accept & pop -> EMPTY.
    - else hold.
  - FULL (occ 2, ready_o=0):
    - pop -> ONE; main<=skid, skid cleared, ready_o=1 from the next cycle.
    - else hold.
- Outputs:
  - Come directly from main register; valid_o=1 in ONE/FULL.
  - Latency: an entry accepted while EMPTY appears on outputs the next cycle.
  - Throughput: 1 entry/cycle with ready_i held high.
  - Strict FIFO order; no entry is duplicated or dropped except by flush.
- Flush:
  - flush_i=1 at an edge: both entries invalidated, occ_o=0, ctrl_o=0, ready_o=1 next cycle.
  - Flush has priority over a same-cycle accept (input dropped) and a same-cycle pop (pop still counts as taken downstream).
  - data_o is not cleared by flush.
- Bubble: ctrl_o is combinationally zero whenever valid_o=0, so downstream RegWrite/MemRead/MemWrite are never asserted by a bubble.
- Stall counter:
  - Increments by 1 on each edge with valid_o=1 && ready_i=0, including the flush cycle if that condition holds.
  - Saturates at 2^CNT_W-1; cleared only by reset.

Test Plan:
- Reset, then valid_i=1, data_i=0x11, ctrl_i=0xA5, ready_i=1 -> next cycle valid_o=1, data_o=0x11, ctrl_o=0xA5, occ_o=1; continuous stream 0x11,0x12,0x13 -> emerges in order, one per cycle, ready_o stays 1.
- ready_i=0, push 0x21 then 0x22 -> occ_o=2, ready_o=0 on the following cycle, data_o=0x21. Raise ready_i -> 0x21 then 0x22 output; ready_o=1 one cycle after first pop.
- FULL state, then flush_i=1 with valid_i=1, data_i=0x33 -> next cycle occ_o=0, valid_o=0, ctrl_o=0, ready_o=1; 0x33 never appears.
- CNT_W=4, valid_o=1, ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15 and stays; ready_i=1 -> no further change.
- rst_i pulled low mid-stream with occ_o=2 (asynchronously, between edges) -> valid_o=0, ctrl_o=0, occ_o=0, stall_cnt_o=0 immediately; after release, first accepted entry 0x44 appears with 1-cycle latency.
- ONE state, simultaneous accept 0x55 and pop of 0x54 -> occ_o stays 1, data_o=0x55 next cycle.
